// File: rtl/bfp16_pkg.sv
// Shared BFP16 definitions: field widths, the packed word layout, canonical constants
// and the pack-case selector used by the round/pack stage.
package bfp16_pkg;

  localparam int BFP16_W      = 16;
  localparam int EXP_W        = 8;
  localparam int FRAC_W       = 7;
  localparam int BIAS         = 127;
  localparam int EXP_ALL_ONES = (1 << EXP_W) - 1;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } bfp16_t;

  localparam logic [BFP16_W-1:0] BFP16_QNAN     = 16'h7FC0;
  localparam logic [BFP16_W-1:0] BFP16_POS_ZERO = 16'h0000;

  // Result class chosen in the pack stage, listed in priority order.
  typedef enum logic [2:0] {
    PK_NAN,
    PK_INF,
    PK_ZERO,
    PK_OVF,
    PK_FTZ,
    PK_NORM
  } pack_sel_e;

endpackage

// File: rtl/bfp16_round_pack_if.sv
// Upstream and downstream valid/ready bus of the BFP16 round/pack stage.
// slave is the block side; master is the side driving operands and taking results.
interface bfp16_round_pack_if
  import bfp16_pkg::*;
#(
  parameter int SIZE_DATA = 32,
  parameter int SIZE_LOPD = 5,
  parameter int SIZE_EXP  = 8
);
  logic                 i_valid;
  logic                 o_ready;
  logic                 i_sign;
  logic [SIZE_EXP-1:0]  i_exponent;
  logic                 i_overflow;
  logic                 i_zero_flag;
  logic [SIZE_LOPD-1:0] i_shift;
  logic [SIZE_DATA-1:0] i_mantissa;
  logic                 i_sticky;
  logic                 i_nan;
  logic                 i_inf;
  logic                 o_valid;
  logic                 i_ready;
  logic [BFP16_W-1:0]   o_result;

  modport slave (
    input  i_valid, i_sign, i_exponent, i_overflow, i_zero_flag, i_shift,
    input  i_mantissa, i_sticky, i_nan, i_inf, i_ready,
    output o_ready, o_valid, o_result
  );

  modport master (
    output i_valid, i_sign, i_exponent, i_overflow, i_zero_flag, i_shift,
    output i_mantissa, i_sticky, i_nan, i_inf, i_ready,
    input  o_ready, o_valid, o_result
  );

endinterface

// File: rtl/bfp16_rne_inc.sv
// Round-to-nearest-even increment decision: round up when past the halfway point,
// or exactly halfway with an odd kept LSB.
module bfp16_rne_inc (
  input  logic lsb,
  input  logic guard,
  input  logic sticky,
  output logic inc
);

  assign inc = guard & (lsb | sticky);

endmodule

// File: rtl/bfp16_round_pack.sv
// Final BFP16 adder stage: RNE rounding to 7 fraction bits, exponent range checks
// and packing, as a 2-stage valid/ready pipeline (S1 round decision, S2 packed output).
module bfp16_round_pack
  import bfp16_pkg::*;
#(
  parameter int SIZE_DATA = 32,
  parameter int SIZE_LOPD = 5,
  parameter int SIZE_EXP  = 8
) (
  input logic               i_clk,
  input logic               i_rst_n,
  bfp16_round_pack_if.slave bus
);

  // Two extra bits keep the adjusted exponent exact: one for carry past 255, one for sign.
  localparam int E_W = SIZE_EXP + 2;
  localparam logic signed [E_W-1:0] E_INF  = E_W'(EXP_ALL_ONES);
  localparam logic signed [E_W-1:0] E_ZERO = '0;

  // ---------------------------------------------------------------- handshake
  logic s1_valid;
  logic out_valid;
  logic s2_load;
  logic s1_load;

  assign s2_load     = ~out_valid | bus.i_ready;
  assign s1_load     = ~s1_valid | s2_load;
  assign bus.o_ready = s1_load;

  // ---------------------------------------------------------------- S1 combinational
  logic           [E_W-1:0] e_adj_d;
  logic                     lsb;
  logic                     guard;
  logic                     sticky;
  logic                     inc_d;

  assign e_adj_d = E_W'(bus.i_exponent) + E_W'(bus.i_overflow) - E_W'(bus.i_shift);
  assign lsb     = bus.i_mantissa[SIZE_DATA-8];
  assign guard   = bus.i_mantissa[SIZE_DATA-9];
  assign sticky  = (|bus.i_mantissa[SIZE_DATA-10:0]) | bus.i_sticky;

  bfp16_rne_inc u_rne_inc (
    .lsb    (lsb),
    .guard  (guard),
    .sticky (sticky),
    .inc    (inc_d)
  );

  // ---------------------------------------------------------------- S1 registers
  logic                     s1_sign;
  logic signed [E_W-1:0]    s1_eadj;
  logic        [7:0]        s1_sig8;
  logic                     s1_inc;
  logic                     s1_nan;
  logic                     s1_inf;
  logic                     s1_zero;

  // NOTE: every flop uses <= so each stage samples the other's pre-edge value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_eadj  <= '0;
      s1_sig8  <= '0;
      s1_inc   <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        s1_sign <= bus.i_sign;
        s1_eadj <= e_adj_d;
        s1_sig8 <= bus.i_mantissa[SIZE_DATA-1:SIZE_DATA-8];
        s1_inc  <= inc_d;
        s1_nan  <= bus.i_nan;
        s1_inf  <= bus.i_inf;
        s1_zero <= bus.i_zero_flag;
      end
    end
  end

  // ---------------------------------------------------------------- S2 combinational
  logic        [8:0]        sum9;
  logic signed [E_W-1:0]    e_fin;
  logic [FRAC_W-1:0]        frac;
  logic                     unused_hidden;
  pack_sel_e                sel;
  bfp16_t                   result_d;

  assign sum9          = {1'b0, s1_sig8} + {8'b0, s1_inc};
  assign e_fin         = s1_eadj + $signed({{(E_W-1){1'b0}}, sum9[8]});
  // On a rounding carry sum9[7:0] is already zero, so the low bits are the fraction either way.
  assign frac          = sum9[FRAC_W-1:0];
  assign unused_hidden = sum9[7];

  // NOTE: defaults assigned first so no path leaves sel or result_d unassigned.
  always_comb begin
    sel = PK_NORM;
    if (s1_nan)               sel = PK_NAN;
    else if (s1_inf)          sel = PK_INF;
    else if (s1_zero)         sel = PK_ZERO;
    else if (e_fin >= E_INF)  sel = PK_OVF;
    else if (e_fin <= E_ZERO) sel = PK_FTZ;
  end

  always_comb begin
    result_d = '{sign: s1_sign, exp: e_fin[EXP_W-1:0], frac: frac};
    unique case (sel)
      PK_NAN:         result_d = BFP16_QNAN;
      PK_INF, PK_OVF: result_d = '{sign: s1_sign, exp: '1, frac: '0};
      PK_ZERO:        result_d = BFP16_POS_ZERO;
      PK_FTZ:         result_d = '{sign: s1_sign, exp: '0, frac: '0};
      default:        ;
    endcase
  end

  // ---------------------------------------------------------------- S2 registers
  logic [BFP16_W-1:0] out_result;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid  <= 1'b0;
      out_result <= BFP16_POS_ZERO;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) out_result <= result_d;
    end
  end

  assign bus.o_valid  = out_valid;
  assign bus.o_result = out_result;

endmodule

// File: tb/tb_bfp16_round_pack.sv
// Directed and randomly back-pressured checks of bfp16_round_pack against
// hand-computed results and an independent integer rounding model.
module tb_bfp16_round_pack;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];

  bfp16_round_pack_if #(.SIZE_DATA(32), .SIZE_LOPD(5), .SIZE_EXP(8)) bus ();

  bfp16_round_pack #(.SIZE_DATA(32), .SIZE_LOPD(5), .SIZE_EXP(8)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, expv, $time);
    end
  endtask

  function automatic logic [15:0] ref_pack(input logic s, input logic [7:0] e, input logic ovf,
                                           input logic zf, input logic [4:0] sh,
                                           input logic [31:0] m, input logic st,
                                           input logic nan, input logic inf);
    int          ex;
    int          sig;
    logic [24:0] rem;
    logic        up;
    logic [31:0] ex_bits;
    logic [31:0] sig_bits;
    ex  = int'(e) + int'(ovf) - int'(sh);
    rem = {m[23:0], st};
    up  = (rem > 25'h100_0000) || ((rem == 25'h100_0000) && m[24]);
    sig = int'(m[31:24]) + int'(up);
    if (sig == 256) begin
      sig = 128;
      ex  = ex + 1;
    end
    ex_bits  = ex;
    sig_bits = sig;
    if (nan)       return 16'h7FC0;
    if (inf)       return {s, 8'hFF, 7'h00};
    if (zf)        return 16'h0000;
    if (ex >= 255) return {s, 8'hFF, 7'h00};
    if (ex <= 0)   return {s, 15'h0000};
    return {s, ex_bits[7:0], sig_bits[6:0]};
  endfunction

  // Ready driver: updates just after each rising edge.
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.i_ready = 1'b0;
        1:       bus.i_ready = 1'b1;
        default: bus.i_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: sampled on the falling edge, the transfer happens at the next rise.
  initial begin
    logic        prev_stall;
    logic [15:0] prev_result;
    exp_t        e;
    prev_stall  = 1'b0;
    prev_result = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", bus.o_valid, 1);
          check("hold_result", bus.o_result, prev_result);
        end
        if (bus.o_valid && bus.i_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", bus.o_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check(e.tag, bus.o_result, e.val);
          end
        end
        prev_stall  = bus.o_valid & ~bus.i_ready;
        prev_result = bus.o_result;
      end
    end
  end

  // Presents one operand (called just after a rising edge) and returns just after
  // the edge that accepted it, with i_valid dropped.
  task automatic send(input string tag, input logic s, input logic [7:0] e, input logic ovf,
                      input logic zf, input logic [4:0] sh, input logic [31:0] m,
                      input logic st, input logic nan, input logic inf,
                      input logic [15:0] expv);
    bit acc;
    int waited;
    acc    = 1'b0;
    waited = 0;
    bus.i_sign      = s;
    bus.i_exponent  = e;
    bus.i_overflow  = ovf;
    bus.i_zero_flag = zf;
    bus.i_shift     = sh;
    bus.i_mantissa  = m;
    bus.i_sticky    = st;
    bus.i_nan       = nan;
    bus.i_inf       = inf;
    bus.i_valid     = 1'b1;
    while (!acc && waited <= 500) begin
      @(negedge clk);
      if (bus.o_ready) acc = 1'b1;
      else waited++;
    end
    if (acc) exp_q.push_back('{tag: tag, val: expv});
    else check("send_timeout", bus.o_ready, 1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        s, ovf, zf, st, nan, inf;
    logic [7:0]  e;
    logic [4:0]  sh;
    logic [31:0] m;

    rst_n           = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_sign      = 1'b0;
    bus.i_exponent  = '0;
    bus.i_overflow  = 1'b0;
    bus.i_zero_flag = 1'b0;
    bus.i_shift     = '0;
    bus.i_mantissa  = '0;
    bus.i_sticky    = 1'b0;
    bus.i_nan       = 1'b0;
    bus.i_inf       = 1'b0;

    #2;
    check("rst_o_valid", bus.o_valid, 0);
    check("rst_o_result", bus.o_result, 16'h0000);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_o_ready", bus.o_ready, 1);

    // T1: basic value and two-cycle latency
    send("t1_one", 0, 8'd127, 0, 0, 5'd0, 32'h8000_0000, 0, 0, 0, 16'h3F80);
    check("t1_lat_s1", bus.o_valid, 0);
    @(posedge clk);
    #1;
    check("t1_lat_s2", bus.o_valid, 1);
    check("t1_result", bus.o_result, 16'h3F80);
    drain();

    // T2..T4 plus exponent boundaries, streamed back to back
    send("t2_tie_even",  0, 8'd127, 0, 0, 5'd0, 32'h8080_0000, 0, 0, 0, 16'h3F80);
    send("t2_tie_odd",   0, 8'd127, 0, 0, 5'd0, 32'h8180_0000, 0, 0, 0, 16'h3F82);
    send("t2_above_tie", 0, 8'd127, 0, 0, 5'd0, 32'h8080_0001, 0, 0, 0, 16'h3F81);
    send("t2_in_sticky", 0, 8'd127, 0, 0, 5'd0, 32'h8080_0000, 1, 0, 0, 16'h3F81);
    send("t3_carry",     0, 8'd127, 0, 0, 5'd0, 32'hFF80_0000, 0, 0, 0, 16'h4000);
    send("t3_ovf_inf",   0, 8'd254, 1, 0, 5'd0, 32'h8000_0000, 0, 0, 0, 16'h7F80);
    send("t3_ftz_neg",   1, 8'd3,   0, 0, 5'd5, 32'h8000_0000, 0, 0, 0, 16'h8000);
    send("t3_carry_inf", 0, 8'd254, 0, 0, 5'd0, 32'hFF80_0000, 0, 0, 0, 16'h7F80);
    send("t3_max_norm",  0, 8'd254, 0, 0, 5'd0, 32'h8000_0000, 0, 0, 0, 16'h7F00);
    send("t3_min_norm",  0, 8'd1,   0, 0, 5'd0, 32'h8000_0000, 0, 0, 0, 16'h0080);
    send("t3_ftz_zero",  0, 8'd1,   0, 0, 5'd1, 32'h8000_0000, 0, 0, 0, 16'h0000);
    send("t4_nan_inf",   0, 8'd127, 0, 0, 5'd0, 32'h8000_0000, 0, 1, 1, 16'h7FC0);
    send("t4_zero_neg",  1, 8'd0,   0, 1, 5'd0, 32'h0000_0000, 0, 0, 0, 16'h0000);
    send("t4_inf_neg",   1, 8'd127, 0, 0, 5'd0, 32'h8000_0000, 0, 0, 1, 16'hFF80);
    drain();

    // T5: back-pressure with both stages filling
    @(negedge clk);
    ready_mode = 0;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send("t5_stream", 0, 8'(127 + i), 0, 0, 5'd0, 32'h8000_0000, 0, 0, 0,
               (i == 0) ? 16'h3F80 : 16'(16'h4000 + 16'h80 * (i - 1)));
      end
      begin
        repeat (3) @(negedge clk);
        check("t5_o_ready_low", bus.o_ready, 0);
        check("t5_o_valid", bus.o_valid, 1);
        check("t5_hold_a", bus.o_result, 16'h3F80);
        @(negedge clk);
        check("t5_hold_b", bus.o_result, 16'h3F80);
        ready_mode = 1;
      end
    join
    drain();

    // Soak: random operands, random gaps, random ready, against the model
    @(negedge clk);
    ready_mode = 2;
    @(posedge clk);
    #1;
    for (int n = 0; n < 10000; n++) begin
      s   = 1'($urandom_range(0, 1));
      e   = 8'($urandom_range(0, 255));
      ovf = 1'($urandom_range(0, 1));
      sh  = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      m   = {1'b1, 31'($urandom)};
      if ($urandom_range(0, 3) == 0) m[22:0] = '0;
      st  = 1'($urandom_range(0, 1));
      nan = ($urandom_range(0, 31) == 0);
      inf = ($urandom_range(0, 31) == 0);
      zf  = ($urandom_range(0, 31) == 0);
      send("soak", s, e, ovf, zf, sh, m, st, nan, inf, ref_pack(s, e, ovf, zf, sh, m, st, nan, inf));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    ready_mode = 1;
    drain();

    // T6: asynchronous reset with both stages occupied
    @(negedge clk);
    ready_mode = 0;
    @(posedge clk);
    #1;
    send("t6_a", 0, 8'd127, 0, 0, 5'd0, 32'h8000_0000, 0, 0, 0, 16'h3F80);
    send("t6_b", 0, 8'd128, 0, 0, 5'd0, 32'h8000_0000, 0, 0, 0, 16'h4000);
    @(negedge clk);
    check("t6_full_valid", bus.o_valid, 1);
    check("t6_full_ready", bus.o_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", bus.o_valid, 0);
    check("t6_async_result", bus.o_result, 16'h0000);
    exp_q.delete();
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_ready_after", bus.o_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_no_stale", bus.o_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
